// File: rtl/arb_mux_pkg.sv
// Shared sizes, FSM state type and pointer helper for the 4-way burst arbiter/mux.
package arb_mux_pkg;
  localparam int N_REQ  = 4;
  localparam int SRC_W  = 2;
  localparam int DATA_W = 4;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_t;

  // Round-robin successor; wraps 3 -> 0 through the 2-bit width.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
    return s + SRC_W'(1);
  endfunction
endpackage

// File: rtl/arb_mux_4_1_if.sv
// Requester and downstream handshake bundle for arb_mux_4_1.
interface arb_mux_4_1_if;
  import arb_mux_pkg::*;

  // Valid/ready: a beat moves on a rising edge where valid && ready. Valid never
  // waits on ready; ready may depend combinationally on valid.
  logic [N_REQ-1:0]  in_valid;
  logic [N_REQ-1:0]  in_last;
  logic [N_REQ-1:0]  in_ready;
  logic [DATA_W-1:0] in_data0;
  logic [DATA_W-1:0] in_data1;
  logic [DATA_W-1:0] in_data2;
  logic [DATA_W-1:0] in_data3;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SRC_W-1:0]  out_src;
  logic              out_last;
  logic              out_ready;

  modport master (
    output in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
    input  in_ready, out_valid, out_data, out_src, out_last
  );

  modport slave (
    input  in_valid, in_last, in_data0, in_data1, in_data2, in_data3, out_ready,
    output in_ready, out_valid, out_data, out_src, out_last
  );
endinterface

// File: rtl/arb_mux_4_1_mux.sv
// Plain 4:1 data selector driven by the arbiter's grant index.
module mux_4_1
  import arb_mux_pkg::*;
(
  input  logic [SRC_W-1:0]  sel,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] d3,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    y = d0;
    case (sel)
      2'd1:    y = d1;
      2'd2:    y = d2;
      2'd3:    y = d3;
      default: y = d0;
    endcase
  end
endmodule

// File: rtl/arb_mux_4_1.sv
// Round-robin arbiter that locks onto a requester for a whole burst and
// forwards one beat per cycle through a single registered output stage.
module arb_mux_4_1
  import arb_mux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  arb_mux_4_1_if.slave      bus,
  output arb_state_t        dbg_state,
  output logic [SRC_W-1:0]  dbg_ptr
);
  arb_state_t        state;
  logic [SRC_W-1:0]  ptr;
  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  grant;
  logic [SRC_W-1:0]  idx;
  logic [SRC_W-1:0]  sel;
  logic              found;
  logic              slot_free;
  logic              accept;
  logic              sel_last;
  logic [N_REQ-1:0]  rdy;
  logic [DATA_W-1:0] sel_data;

  // First valid requester at or after ptr, wrapping modulo 4.
  always_comb begin
    grant = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + SRC_W'(k);
      if (!found && bus.in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign sel       = (state == BURST) ? owner : grant;
  assign slot_free = !bus.out_valid || bus.out_ready;

  // A locked burst keeps ready on its owner even while the owner is idle.
  always_comb begin
    rdy = '0;
    if (rst_n && slot_free && ((state == BURST) || found)) rdy[sel] = 1'b1;
  end

  assign bus.in_ready = rdy;
  assign accept       = |(bus.in_valid & rdy);
  assign sel_last     = bus.in_last[sel];
  assign dbg_state    = state;
  assign dbg_ptr      = ptr;

  mux_4_1 u_mux (
    .sel (sel),
    .d0  (bus.in_data0),
    .d1  (bus.in_data1),
    .d2  (bus.in_data2),
    .d3  (bus.in_data3),
    .y   (sel_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_src   <= '0;
      bus.out_last  <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_src   <= sel;
      bus.out_last  <= sel_last;
      case (state)
        IDLE: begin
          if (sel_last) begin
            ptr <= next_src(sel);
          end else begin
            state <= BURST;
            owner <= sel;
          end
        end
        BURST: begin
          if (sel_last) begin
            state <= IDLE;
            ptr   <= next_src(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end
endmodule

// File: doc/arb_mux_4_1.md
ARB_MUX_4_1 -- requirements
Module: arb_mux_4_1

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 4 bits and requester count at 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  4  per-requester beat valid.
REQ-005 in_last  input  4  per-requester last-beat-of-burst flag, qualified by in_valid.
REQ-006 in_data0, in_data1, in_data2, in_data3  input  4 each  requester data.
REQ-007 in_ready  output  4  per-requester accept; a beat transfers when in_valid[i] && in_ready[i].
REQ-008 out_valid  output  1  registered output beat valid.
REQ-009 out_data  output  4  registered selected data.
REQ-010 out_src  output  2  index of requester that supplied out_data.
REQ-011 out_last  output  1  registered copy of the accepted beat's in_last.
REQ-012 out_ready  input  1  downstream accept; output transfers when out_valid && out_ready.

Function
REQ-013 slot_free SHALL be (!out_valid || out_ready); no beat SHALL be accepted when slot_free is 0.
REQ-014 The FSM SHALL have exactly two states: IDLE (no burst owner) and BURST (grant locked to owner).
REQ-015 In IDLE the grant g SHALL be the first i with in_valid[i] set, searching ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-016 In IDLE, in_ready SHALL be one-hot at g when any in_valid is set and slot_free is 1; otherwise all zero.
REQ-017 In BURST, in_ready SHALL be one-hot at owner when slot_free is 1; otherwise all zero; other requesters SHALL be ignored.
REQ-018 IDLE accept with in_last[g]=1: remain IDLE, ptr <= g+1 mod 4.
REQ-019 IDLE accept with in_last[g]=0: go to BURST, owner <= g, ptr unchanged.
REQ-020 BURST accept with in_last[owner]=1: go to IDLE, ptr <= owner+1 mod 4; with in_last=0 remain in BURST.
REQ-021 BURST with in_valid[owner]=0: hold state, owner and ptr; no timeout.
REQ-022 On accept, out_data/out_src/out_last SHALL load the selected requester's values and out_valid SHALL be 1 on the next cycle (latency 1).
REQ-023 Without accept, out_valid SHALL clear if out_ready=1, else out_valid/out_data/out_src/out_last SHALL hold.
REQ-024 Simultaneous output drain and new accept in one cycle SHALL sustain one beat per cycle with no bubble.
REQ-025 ptr wraps 3 -> 0; all four requesters continuously valid with single-beat bursts SHALL be served 0,1,2,3,0,...
REQ-026 in_ready SHALL depend combinationally on in_valid and out_ready; in_valid SHALL NOT be required to depend on in_ready.

Reset
REQ-027 While rst_n=0: state=IDLE, ptr=0, owner=0, out_valid=0, out_data=0, out_src=0, out_last=0, in_ready=0.
REQ-028 Reset asserted mid-burst SHALL abandon the burst; the dropped beat in the output register is lost, no recovery.
REQ-029 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Package arb_mux_pkg SHALL hold N_REQ=4, SRC_W=2, DATA_W=4 and the enum typedef arb_state_t {IDLE, BURST}.
REQ-031 Data selection SHALL use one mux_4_1 instance driven by the 2-bit grant index; grant/priority logic stays in arb_mux_4_1.

Verification
REQ-032 Reset, then in_valid=4'b1111, all in_last=1, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3, out_valid continuous.
REQ-033 Requester 2 sends 3-beat burst A,B,C (last on C) while requester 0 valid -> out 2:A,2:B,2:C, then 0; in_ready[0]=0 during burst.
REQ-034 out_ready=0 with out_valid=1 for 5 cycles -> in_ready=4'b0000, out_data/out_src stable; release -> next beat one cycle later.
REQ-035 Burst owner 1 drops in_valid for 3 cycles mid-burst while requester 3 valid -> requester 3 not granted; burst resumes on 1.
REQ-036 rst_n pulsed low mid-burst of requester 0 -> out_valid=0 immediately, state IDLE, next grant starts from ptr=0.
REQ-037 Only in_valid[3] set after ptr=3 path -> grant 3, ptr wraps to 0; next simultaneous 0 and 3 valid -> 0 served first.
